led_bank_arbiter: RTL and testbench

Round-robin arbiter that shares the board's 4-bit LED bank among four pattern requesters (FSM display, debug counters, status flags, etc.) on the Basys3 fabric. Each requester presents a 4-bit pattern and a request. The arbiter grants one owner at a time and enforces a minimum dwell time so patterns stay visible. It rotates ownership on release, on a debounced button "skip" pulse, or on a hold timeout. It sits between the pattern sources and the `led` pins.

---
 rtl/led_bank_arbiter.sv | 130 +++++++++++++
 tb/tb_led_bank_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_bank_arbiter.sv
// Round-robin owner of the 4-bit LED bank shared by four pattern requesters.
// Enforces a minimum dwell before skip, preempts on timeout, and blanks LEDs for one cycle on handover.
module led_bank_arbiter #(
    parameter int unsigned DWELL_CYCLES   = 50000,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [15:0] req_pat,
    input  logic        skip,
    output logic [3:0]  gnt,
    output logic [1:0]  owner,
    output logic        busy,
    output logic [3:0]  led
);

    localparam int unsigned CNT_W     = 32;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_MIN = CNT_W'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_OWN    = 2'd1,
        S_SWITCH = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         last_q, last_d;
    logic [3:0]         gnt_d;
    logic [1:0]         owner_d;
    logic               busy_d;
    logic [3:0]         led_d;

    logic               any_req;
    logic               others;
    logic               exit_own;
    logic [1:0]         pick;
    logic [3:0]         own_pat;

    // First requester after last, wrapping; the previous owner is checked last.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] l);
        logic [1:0] idx;
        rr_pick = l;
        for (int k = 4; k >= 1; k--) begin
            idx = l + 2'(k);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    always_comb begin
        any_req  = |req;
        others   = |(req & ~gnt);
        pick     = rr_pick(req, last_q);
        own_pat  = req_pat[{owner, 2'b00} +: 4];
        exit_own = !req[owner]
                 || (skip && (cnt_q >= DWELL_MIN) && others)
                 || ((cnt_q == CNT_MAX) && others);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            last_q  <= 2'd3;
            gnt     <= '0;
            owner   <= '0;
            busy    <= 1'b0;
            led     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            gnt     <= gnt_d;
            owner   <= owner_d;
            busy    <= busy_d;
            led     <= led_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (any_req) state_d = S_OWN;
            S_OWN:    if (exit_own) state_d = S_SWITCH;
            S_SWITCH: state_d = any_req ? S_OWN : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        gnt_d   = gnt;
        owner_d = owner;
        busy_d  = busy;
        led_d   = led;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE, S_SWITCH: begin
                gnt_d  = '0;
                busy_d = 1'b0;
                led_d  = '0;
                if (any_req) begin
                    gnt_d   = 4'b0001 << pick;
                    owner_d = pick;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            S_OWN: begin
                if (exit_own) begin
                    gnt_d  = '0;
                    busy_d = 1'b0;
                    led_d  = '0;
                    last_d = owner;
                end else begin
                    led_d = own_pat;
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                end
            end
            default: begin
                gnt_d  = '0;
                busy_d = 1'b0;
                led_d  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Bench for led_bank_arbiter: directed scenarios plus random traffic against a cycle-level reference model.
module tb_led_bank_arbiter;

    localparam int unsigned D = 4;
    localparam int unsigned T = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [15:0] req_pat = '0;
    logic        skip = 1'b0;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic        busy;
    logic [3:0]  led;

    int n_vec = 0;
    int n_err = 0;

    led_bank_arbiter #(.DWELL_CYCLES(D), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .req(req), .req_pat(req_pat), .skip(skip),
        .gnt(gnt), .owner(owner), .busy(busy), .led(led)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference model: phase 0 = no owner, 1 = owned, 2 = blank gap between owners.
    int         m_phase, m_cnt, m_last, m_own;
    logic [3:0] m_gnt, m_led;
    logic       m_busy;

    function automatic int m_pick(input logic [3:0] r, input int l);
        for (int k = 1; k <= 4; k++) if (r[(l + k) % 4]) return (l + k) % 4;
        return l;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_cnt = 0; m_last = 3; m_own = 0;
            m_gnt = '0; m_led = '0; m_busy = 1'b0;
        end else if (m_phase == 1) begin
            bit others;
            others = (req & ~m_gnt) != 4'b0;
            if (!req[m_own] || (skip && m_cnt >= int'(D) - 1 && others) || (m_cnt == int'(T) - 1 && others)) begin
                m_last = m_own; m_phase = 2;
                m_gnt = '0; m_busy = 1'b0; m_led = '0;
            end else begin
                m_led = 4'((req_pat >> (4 * m_own)) & 16'hF);
                if (m_cnt < int'(T) - 1) m_cnt++;
            end
        end else begin
            m_led = '0;
            if (req != 4'b0) begin
                m_own = m_pick(req, m_last);
                m_gnt = 4'(1 << m_own); m_busy = 1'b1; m_cnt = 0; m_phase = 1;
            end else begin
                m_gnt = '0; m_busy = 1'b0; m_phase = 0;
            end
        end
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1; req = '0; skip = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(); tick();
        n_vec++; if (gnt !== 4'b0)  begin n_err++; $display("FAIL reset_gnt got %b want 0000", gnt); end
        n_vec++; if (led !== 4'b0)  begin n_err++; $display("FAIL reset_led got %h want 0", led); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (owner !== 2'd0) begin n_err++; $display("FAIL reset_owner got %0d want 0", owner); end
        rst = 1'b0;
    endtask

    task automatic test_first_grant;
        do_reset();
        req = 4'b1010; req_pat = 16'h5A00;
        tick();
        n_vec++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL first_gnt got %b want 0010", gnt); end
        n_vec++; if (owner !== 2'd1 || busy !== 1'b1) begin n_err++; $display("FAIL first_owner got %0d/%b want 1/1", owner, busy); end
        tick();
        n_vec++; if (led !== 4'h0) begin n_err++; $display("FAIL first_led got %h want 0", led); end
        req_pat = 16'h0070;
        tick();
        n_vec++; if (led !== 4'h7) begin n_err++; $display("FAIL first_led_track got %h want 7", led); end
    endtask

    task automatic test_rotation;
        int cur, nxt;
        do_reset();
        req = 4'b1111; req_pat = 16'h8421;
        tick();
        n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL rot_start got %b want 0001", gnt); end
        tick();
        cur = 0;
        for (int i = 0; i < 4; i++) begin
            nxt = (cur + 1) % 4;
            req = 4'b1111 & ~4'(1 << cur);
            tick();
            n_vec++; if (gnt !== 4'b0 || led !== 4'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rot_gap gnt/led/busy got %b/%h/%b want 0000/0/0", gnt, led, busy); end
            tick();
            n_vec++; if (gnt !== 4'(1 << nxt)) begin n_err++; $display("FAIL rot_gnt got %b want %b", gnt, 4'(1 << nxt)); end
            req = 4'b1111;
            tick();
            n_vec++; if (led !== 4'(1 << nxt)) begin n_err++; $display("FAIL rot_led got %h want %h", led, 4'(1 << nxt)); end
            cur = nxt;
        end
    endtask

    task automatic test_dwell_skip;
        do_reset();
        req = 4'b0100;
        tick();
        n_vec++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL dwell_own got %b want 0100", gnt); end
        req = 4'b0101;
        tick();
        skip = 1'b1;
        tick();
        skip = 1'b0;
        n_vec++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL dwell_early_skip got %b want 0100", gnt); end
        tick();
        n_vec++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL dwell_hold got %b want 0100", gnt); end
        skip = 1'b1;
        tick();
        skip = 1'b0;
        n_vec++; if (gnt !== 4'b0 || led !== 4'b0) begin n_err++; $display("FAIL dwell_switch gnt/led got %b/%h want 0000/0", gnt, led); end
        tick();
        n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL dwell_next got %b want 0001", gnt); end
    endtask

    task automatic test_timeout;
        do_reset();
        req = 4'b0011;
        tick();
        for (int i = 1; i <= int'(T) - 1; i++) begin
            tick();
            n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL tmo_hold cyc %0d got %b want 0001", i, gnt); end
        end
        tick();
        n_vec++; if (gnt !== 4'b0) begin n_err++; $display("FAIL tmo_switch got %b want 0000", gnt); end
        tick();
        n_vec++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL tmo_next got %b want 0010", gnt); end
        do_reset();
        req = 4'b0001;
        tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL tmo_sat cyc %0d got %b want 0001", i, gnt); end
        end
        req = 4'b0011;
        tick();
        n_vec++; if (gnt !== 4'b0) begin n_err++; $display("FAIL tmo_sat_switch got %b want 0000", gnt); end
        tick();
        n_vec++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL tmo_sat_next got %b want 0010", gnt); end
    endtask

    task automatic test_simultaneous;
        do_reset();
        req = 4'b0011;
        tick(); tick(); tick(); tick();
        req = 4'b0010; skip = 1'b1;
        tick();
        skip = 1'b0;
        n_vec++; if (gnt !== 4'b0 || busy !== 1'b0) begin n_err++; $display("FAIL simul_gap gnt/busy got %b/%b want 0000/0", gnt, busy); end
        tick();
        n_vec++; if (gnt !== 4'b0010 || busy !== 1'b1) begin n_err++; $display("FAIL simul_single gnt/busy got %b/%b want 0010/1", gnt, busy); end
        do_reset();
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick();
        n_vec++; if (gnt !== 4'b0) begin n_err++; $display("FAIL late_gap got %b want 0000", gnt); end
        req = 4'b1000;
        tick();
        n_vec++; if (gnt !== 4'b1000 || owner !== 2'd3) begin n_err++; $display("FAIL late_req gnt/owner got %b/%0d want 1000/3", gnt, owner); end
    endtask

    task automatic test_async_reset;
        do_reset();
        req = 4'b1111; req_pat = 16'h8421;
        tick();
        req = 4'b1110;
        tick();
        req = 4'b1111;
        tick(); tick();
        n_vec++; if (led !== 4'h2 || busy !== 1'b1) begin n_err++; $display("FAIL arst_pre led/busy got %h/%b want 2/1", led, busy); end
        #2 rst = 1'b1;
        #1;
        n_vec++; if (gnt !== 4'b0 || led !== 4'b0 || busy !== 1'b0) begin n_err++; $display("FAIL arst_drop gnt/led/busy got %b/%h/%b want 0000/0/0", gnt, led, busy); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL arst_regrant got %b want 0001", gnt); end
    endtask

    task automatic test_random;
        do_reset();
        req = '0;
        for (int i = 0; i < 600; i++) begin
            req     = req ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
            req_pat = 16'($urandom);
            skip    = ($urandom_range(0, 5) == 0);
            tick();
            n_vec++; if (gnt !== m_gnt)   begin n_err++; $display("FAIL rnd_gnt cyc %0d got %b want %b", i, gnt, m_gnt); end
            n_vec++; if (led !== m_led)   begin n_err++; $display("FAIL rnd_led cyc %0d got %h want %h", i, led, m_led); end
            n_vec++; if (busy !== m_busy) begin n_err++; $display("FAIL rnd_busy cyc %0d got %b want %b", i, busy, m_busy); end
            if (m_busy) begin
                n_vec++; if (owner !== 2'(m_own)) begin n_err++; $display("FAIL rnd_owner cyc %0d got %0d want %0d", i, owner, m_own); end
            end
            n_vec++; if ($countones(gnt) > 1 || (!busy && gnt !== 4'b0)) begin n_err++; $display("FAIL rnd_onehot cyc %0d gnt %b busy %b", i, gnt, busy); end
        end
        skip = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_grant();
        test_rotation();
        test_dwell_skip();
        test_timeout();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
